// File: rtl/rf_wr_arbiter_pkg.sv
// Shared defaults, FSM state type and requester indices for the register-file write arbiter.
package rf_wr_arbiter_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned NUM_REGS_DEF = 8;
    localparam int unsigned ADDR_W_DEF   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Write-request, ack and read-port bundle between the two requesters and rf_wr_arbiter.
interface rf_wr_arbiter_if
    import rf_wr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;
    logic              ack0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;
    logic              ack1;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1, rd_addr,
        output ack0, ack1, rd_data, busy
    );

    modport master (
        output req0, addr0, data0, req1, addr1, data1, rd_addr,
        input  ack0, ack1, rd_data, busy
    );
endinterface

// File: rtl/rf_wr_arbiter_bank.sv
// Register bank: enable-gated registers, one-hot write decoder and combinational read mux.
module rf_en_reg #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q_q <= '0;
        else if (en_i)
            q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

module rf_bank #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [NUM_REGS-1:0] en;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    always_comb begin
        en = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (we_i && (waddr_i == ADDR_W'(i)))
                en[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        rf_en_reg #(.W(DATA_W)) u_reg (
            .clk  (clk),
            .rst  (rst),
            .en_i (en[g]),
            .d_i  (wdata_i),
            .q_o  (regs[g])
        );
    end

    assign rdata_o = regs[raddr_i];
endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the bank's single write port between two requesters.
// Optional macro RF_BYPASS_EN forwards the pending write to rd_data during WRITE.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    rf_wr_arbiter_if.slave      bus
);
    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              gnt_q, gnt_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              sel;
    logic              we;
    logic [DATA_W-1:0] bank_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= REQ0;
            gnt_q       <= REQ0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        sel         = REQ0;
        we          = 1'b0;
        bus.ack0    = 1'b0;
        bus.ack1    = 1'b0;
        bus.busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Pointer only breaks ties; a lone requester always wins.
                    if (bus.req0 && bus.req1)
                        sel = ptr_q;
                    else if (bus.req1)
                        sel = REQ1;
                    else
                        sel = REQ0;
                    gnt_d       = sel;
                    pend_addr_d = (sel == REQ1) ? bus.addr1 : bus.addr0;
                    pend_data_d = (sel == REQ1) ? bus.data1 : bus.data0;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                bus.busy = 1'b1;
                we       = 1'b1;
                bus.ack0 = (gnt_q == REQ0);
                bus.ack1 = (gnt_q == REQ1);
                ptr_d    = ~gnt_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    rf_bank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (pend_addr_q),
        .wdata_i (pend_data_q),
        .raddr_i (bus.rd_addr),
        .rdata_o (bank_rd)
    );

    always_comb begin
        bus.rd_data = bank_rd;
`ifdef RF_BYPASS_EN
        if ((state_q == WRITE) && (bus.rd_addr == pend_addr_q))
            bus.rd_data = pend_data_q;
`endif
    end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: edge-indexed transaction model checked every cycle plus literal checks.
module tb_rf_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rf_wr_arbiter_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    rf_wr_arbiter #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: a grant sampled at edge e makes the interval after e the ack cycle,
    // commits the data at edge e+1 and blocks new grants until edge e+2.
    int          cyc     = 0;
    int          free_at = 0;
    int          ack_at  = -1;
    bit          ack_who = 1'b0;
    bit          prio    = 1'b0;
    bit          c_valid = 1'b0;
    int          c_at    = 0;
    logic [2:0]  c_addr  = '0;
    logic [15:0] c_data  = '0;
    logic [15:0] m_regs [8];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            foreach (m_regs[i]) m_regs[i] = 16'h0000;
            c_valid = 1'b0;
            ack_at  = -1;
            free_at = 0;
            prio    = 1'b0;
        end else begin
            cyc++;
            if (c_valid && cyc == c_at) begin
                m_regs[c_addr] = c_data;
                c_valid        = 1'b0;
            end
            if (cyc >= free_at && (bus.req0 || bus.req1)) begin
                ack_who = (bus.req0 && bus.req1) ? prio : bus.req1;
                ack_at  = cyc;
                c_valid = 1'b1;
                c_at    = cyc + 1;
                c_addr  = ack_who ? bus.addr1 : bus.addr0;
                c_data  = ack_who ? bus.data1 : bus.data0;
                free_at = cyc + 2;
                prio    = ~ack_who;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            bit          in_wr;
            logic [15:0] exp_rd;
            in_wr  = rst && (cyc == ack_at);
            exp_rd = m_regs[bus.rd_addr];
`ifdef RF_BYPASS_EN
            if (in_wr && c_valid && bus.rd_addr == c_addr)
                exp_rd = c_data;
`endif
            chk("model_busy", 32'(bus.busy), 32'(in_wr));
            chk("model_ack0", 32'(bus.ack0), 32'(in_wr && ack_who == 1'b0));
            chk("model_ack1", 32'(bus.ack1), 32'(in_wr && ack_who == 1'b1));
            chk("model_rd_data", 32'(bus.rd_data), 32'(exp_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int ack_seq [$];
    int repeats;

    initial begin
        bus.req0 = 1'b0; bus.addr0 = '0; bus.data0 = '0;
        bus.req1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
        bus.rd_addr = '0;
        repeat (2) @(posedge clk);
        #2;
        rst      = 1'b1;
        checking = 1'b1;

        // Contention straight out of reset
        bus.req0 = 1'b1; bus.addr0 = 3'd1; bus.data0 = 16'hAAAA;
        bus.req1 = 1'b1; bus.addr1 = 3'd2; bus.data1 = 16'h5555;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_acks", 32'({bus.ack0, bus.ack1}), 32'd0);
        chk("reset_rd_data", 32'(bus.rd_data), 32'h0000);
        tick();
        @(negedge clk);
        chk("cont_first_ack0", 32'({bus.ack0, bus.ack1}), 32'b10);
        tick();
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("cont_gap_acks", 32'({bus.ack0, bus.ack1}), 32'b00);
        tick();
        @(negedge clk);
        chk("cont_second_ack1", 32'({bus.ack0, bus.ack1}), 32'b01);
        tick();
        bus.req1 = 1'b0;
        bus.rd_addr = 3'd1;
        #1 chk("cont_reg1", 32'(bus.rd_data), 32'hAAAA);
        bus.rd_addr = 3'd2;
        #1 chk("cont_reg2", 32'(bus.rd_data), 32'h5555);

        // Fairness: both requesters held for 8 edges
        bus.req0 = 1'b1; bus.addr0 = 3'd0; bus.data0 = 16'h1111;
        bus.req1 = 1'b1; bus.addr1 = 3'd6; bus.data1 = 16'h6666;
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge clk);
            if (bus.ack0) ack_seq.push_back(0);
            if (bus.ack1) ack_seq.push_back(1);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("fair_ack_count", 32'(ack_seq.size()), 32'd4);
        if (ack_seq.size() == 4) begin
            chk("fair_ack_order", 32'({ack_seq[0][0], ack_seq[1][0], ack_seq[2][0], ack_seq[3][0]}),
                32'b0101);
        end
        repeats = 0;
        for (int i = 1; i < ack_seq.size(); i++)
            if (ack_seq[i] == ack_seq[i-1]) repeats++;
        chk("fair_no_repeat", 32'(repeats), 32'd0);

        // Single write from requester 0
        tick();
        bus.req0 = 1'b1; bus.addr0 = 3'd5; bus.data0 = 16'h1234;
        bus.rd_addr = 3'd5;
        tick();
        @(negedge clk);
        chk("single_ack", 32'({bus.ack0, bus.ack1}), 32'b10);
`ifdef RF_BYPASS_EN
        chk("single_rd_n1", 32'(bus.rd_data), 32'h1234);
`else
        chk("single_rd_n1", 32'(bus.rd_data), 32'h0000);
`endif
        tick();
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("single_ack_done", 32'({bus.ack0, bus.ack1}), 32'b00);
        chk("single_rd_n2", 32'(bus.rd_data), 32'h1234);

        // Same-address race with addr0/data0 disturbed during WRITE
        tick();
        bus.req0 = 1'b1; bus.addr0 = 3'd7; bus.data0 = 16'h0001;
        bus.rd_addr = 3'd7;
        tick();
        bus.addr0 = 3'd6; bus.data0 = 16'hFFFF;
        bus.req1 = 1'b1; bus.addr1 = 3'd7; bus.data1 = 16'h0002;
        tick();
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("race_first", 32'(bus.rd_data), 32'h0001);
        tick();
        tick();
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("race_final", 32'(bus.rd_data), 32'h0002);
        #1 bus.rd_addr = 3'd6;
        #1 chk("race_reg6_untouched", 32'(bus.rd_data), 32'h6666);

        // Read-after-write on reg 4
        tick();
        bus.req0 = 1'b1; bus.addr0 = 3'd4; bus.data0 = 16'hCAFE;
        bus.rd_addr = 3'd4;
        tick();
        @(negedge clk);
`ifdef RF_BYPASS_EN
        chk("bypass_n1", 32'(bus.rd_data), 32'hCAFE);
`else
        chk("bypass_n1", 32'(bus.rd_data), 32'h0000);
`endif
        tick();
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("bypass_n2", 32'(bus.rd_data), 32'hCAFE);

        // Reset asserted in the WRITE cycle of 0xBEEF to reg 3
        tick();
        bus.req0 = 1'b1; bus.addr0 = 3'd3; bus.data0 = 16'hBEEF;
        bus.rd_addr = 3'd3;
        tick();
        rst = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("rst_mid_ack0", 32'(bus.ack0), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_reg3", 32'(bus.rd_data), 32'h0000);
        chk("rst_busy_after", 32'(bus.busy), 32'd0);
        #1 bus.rd_addr = 3'd4;
        #1 chk("rst_reg4_cleared", 32'(bus.rd_data), 32'h0000);
        repeat (3) tick();

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Owns a bank of NUM_REGS x DATA_W registers, each built from the team's enable-gated 16-bit register.
- Shares the bank's single write port between two requesters using a round-robin req/ack handshake.
- Provides one combinational read port.
- Sits between the decode/writeback stage (requester 0) and the load-return path (requester 1) of the datapath.

Parameters:
- DATA_W, 16: register and data width.
- NUM_REGS, 8: number of registers in the bank.
- ADDR_W, 3: register address width; must equal clog2(NUM_REGS).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0  input  1  write request, requester 0.
- addr0  input  ADDR_W  write address, requester 0.
- data0  input  DATA_W  write data, requester 0.
- ack0  output  1  one-cycle write-done pulse to requester 0.
- req1  input  1  write request, requester 1.
- addr1  input  ADDR_W  write address, requester 1.
- data1  input  DATA_W  write data, requester 1.
- ack1  output  1  one-cycle write-done pulse to requester 1.
- rd_addr  input  ADDR_W  read address.
- rd_data  output  DATA_W  combinational read data.
- busy  output  1  high while in WRITE state.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - Priority pointer goes to 0 (requester 0 favoured).
  - All registers clear to 0.
  - ack0=ack1=0, busy=0, rd_data=0.
  - Reset asserted mid-WRITE abandons the write: no register updated, no ack issued.
- FSM states IDLE and WRITE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant the requester named by the priority pointer.
  - On grant: latch its addr/data into a pending-write holding register and go to WRITE next cycle.
- WRITE:
  - busy=1.
  - The enable of register [pending addr] is asserted; the bank captures the pending data at the end of this cycle.
  - ack of the granted requester = 1 for exactly this cycle.
  - Priority pointer is set to the other requester.
  - Next state is IDLE unconditionally.
- Latency and throughput:
  - req sampled in IDLE at edge N, ack high during cycle N+1.
  - Register value visible on rd_data from cycle N+2.
  - Maximum throughput is one write per 2 cycles.
- Handshake rules:
  - A requester holds req, addr and data stable until it sees ack, then drops req on the following edge.
  - req still high in the IDLE cycle after ack is treated as a new request.
  - Requests arriving during WRITE are not sampled; they are evaluated in the next IDLE.
  - addr/data changes during WRITE have no effect, because the holding register is used.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1 and neither waits more than 4 cycles.
- Only one register enable is ever asserted per cycle; the others recirculate their value.
- rd_data = reg[rd_addr], with no stall and no dependence on FSM state (except as modified by RF_BYPASS_EN).

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: during WRITE, if rd_addr equals the pending address, rd_data returns the pending data, giving read-after-write visibility in cycle N+1.
- Undefined: rd_data returns the old register contents until cycle N+2.

Decomposition:
- Shared package holds:
  - DATA_W, NUM_REGS and ADDR_W defaults.
  - FSM state encoding: IDLE=1'b0, WRITE=1'b1.
  - Requester index constants REQ0=1'b0 and REQ1=1'b1.
- One natural sub-module, rf_bank:
  - NUM_REGS instances of the enable-gated 16-bit register.
  - One-hot enable decoder from write address plus write-valid.
  - Read multiplexer.
- The arbiter FSM, priority pointer and holding register stay in rf_wr_arbiter.

Test Plan:
- Reset: drive rst=0 mid-WRITE of 0xBEEF to reg 3 → no ack, reg 3 reads 0x0000 after release, busy=0.
- Single write: req0, addr0=5, data0=0x1234 at edge N → ack0 high cycle N+1 only, ack1=0, rd_addr=5 gives 0x1234 from N+2.
- Contention: req0 (addr 1, 0xAAAA) and req1 (addr 2, 0x5555) together from reset → requester 0 acked first, requester 1 acked 2 cycles later, reg1=0xAAAA, reg2=0x5555.
- Fairness: both req held continuously for 8 cycles, each requester re-requesting after ack → ack sequence 0,1,0,1; never two consecutive acks to the same requester.
- Same-address race: req0 (addr 7, 0x0001), then req1 (addr 7, 0x0002) → final reg 7 = 0x0002; changing addr0/data0 during WRITE does not alter the written value.
- Bypass: write 0xCAFE to reg 4 with rd_addr=4 → cycle N+1 rd_data=0xCAFE with RF_BYPASS_EN defined, old value without it; 0xCAFE from N+2 in both builds.
